// File: rtl/digit_serial_sub_16bit_pkg.sv
// rtl/digit_serial_sub_16bit_pkg.sv - shared state encoding and size defaults for the digit-serial subtractor
package digit_serial_sub_16bit_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DIGIT_W = 4;
    localparam int DEF_NDIG    = DEF_WIDTH / DEF_DIGIT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/digit_serial_sub_16bit_sub_digit.sv
// rtl/digit_serial_sub_16bit_sub_digit.sv - combinational DIGIT_W-bit borrow-ripple subtractor
module digit_serial_sub_16bit_sub_digit #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bi,
    output logic [DIGIT_W-1:0] d,
    output logic               bo
);

    // br[i] is the borrow flowing into bit i; br[DIGIT_W] leaves the digit.
    logic [DIGIT_W:0] br;

    assign br[0] = bi;

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_fs
        // One full subtractor: x - y - borrow, borrow out when the result goes negative.
        assign d[i]    = x[i] ^ y[i] ^ br[i];
        assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end

    assign bo = br[DIGIT_W];

endmodule

// File: rtl/digit_serial_sub_16bit.sv
// rtl/digit_serial_sub_16bit.sv - multi-cycle subtractor D = a - b - bin, one digit per clock, LSB first
module digit_serial_sub_16bit
    import digit_serial_sub_16bit_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DIGIT_W = DEF_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int MSB   = WIDTH - 1;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               borrow_reg;
    logic [CNT_W-1:0]   cnt;

    logic [DIGIT_W-1:0] dig_a;
    logic [DIGIT_W-1:0] dig_b;
    logic [DIGIT_W-1:0] dig_d;
    logic               dig_bo;
    logic [WIDTH-1:0]   d_next;
    logic               last_dig;
    logic               accept;

    assign dig_a    = a_r[cnt*DIGIT_W +: DIGIT_W];
    assign dig_b    = b_r[cnt*DIGIT_W +: DIGIT_W];
    assign last_dig = (cnt == CNT_W'(NDIG - 1));
    assign accept   = start && (state != ST_RUN);

    digit_serial_sub_16bit_sub_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_sub_digit (
        .x  (dig_a),
        .y  (dig_b),
        .bi (borrow_reg),
        .d  (dig_d),
        .bo (dig_bo)
    );

    // Difference as it will look once the current digit is written; flags on the last digit use it.
    always_comb begin
        d_next = D;
        d_next[cnt*DIGIT_W +: DIGIT_W] = dig_d;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; start is honoured in IDLE and DONE but not in RUN.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_dig) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, per-digit write-back with borrow chaining, and flags latched on the final digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            D          <= '0;
            Bout       <= 1'b0;
            V          <= 1'b0;
            Z          <= 1'b0;
        end else if (accept) begin
            a_r        <= a;
            b_r        <= b;
            borrow_reg <= bin;
            cnt        <= '0;
        end else if (state == ST_RUN) begin
            D          <= d_next;
            borrow_reg <= dig_bo;
            cnt        <= cnt + CNT_W'(1);
            if (last_dig) begin
                Bout <= dig_bo;
                V    <= (a_r[MSB] != b_r[MSB]) && (d_next[MSB] != a_r[MSB]);
                Z    <= (d_next == '0);
            end
        end
    end

endmodule
